// File: rtl/x25519_job_controller_if.sv
// Request/response/core bundle for the X25519 job controller.
//   req_*  : job offer (u-coordinate, scalar) with valid/ready handshake
//   resp_* : 256-bit result plus timeout qualifier with valid/ready handshake
//   core_* : start pulse and operands to the core, result strobe back
// slave  : controller view (serves jobs, drives the core)
// master : requester/environment view
interface x25519_job_controller_if;
   logic         req_valid;
   logic         req_ready;
   logic [255:0] req_work_in;
   logic [255:0] req_e;

   logic         resp_valid;
   logic         resp_ready;
   logic [255:0] resp_data;
   logic         resp_timeout;

   logic         core_en;
   logic [255:0] core_work_in;
   logic [255:0] core_e;
   logic         core_out_valid;
   logic [255:0] core_work_out;

   modport slave (
      input  req_valid, req_work_in, req_e, resp_ready, core_out_valid, core_work_out,
      output req_ready, resp_valid, resp_data, resp_timeout, core_en, core_work_in, core_e
   );

   modport master (
      output req_valid, req_work_in, req_e, resp_ready, core_out_valid, core_work_out,
      input  req_ready, resp_valid, resp_data, resp_timeout, core_en, core_work_in, core_e
   );
endinterface

// File: rtl/x25519_job_controller.sv
// Initiator-side sequencer for the X25519 scalar-multiply core.
// Accepts one job, issues a single-cycle core_en with stable operands, waits for the core
// result (or a watchdog abort) and returns it over the response handshake.
// Ports:
//   clk       : clock
//   rst       : synchronous reset, active high
//   bus       : request/response/core bundle (slave view)
//   busy      : high whenever the controller is not idle
//   err_stray : sticky, core result strobe seen while not waiting for one
module x25519_job_controller #(
   parameter int unsigned TIMEOUT = 1000000,
   localparam int unsigned CNT_BITS = $clog2(TIMEOUT + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   x25519_job_controller_if.slave  bus,
   output logic                    busy,
   output logic                    err_stray
);

   typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

   state_e                state_q, state_d;
   logic                  core_en_q, core_en_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_timeout_q, resp_timeout_d;
   logic                  err_stray_q, err_stray_d;
   logic [255:0]          resp_data_q, resp_data_d;
   logic [255:0]          core_work_in_q, core_work_in_d;
   logic [255:0]          core_e_q, core_e_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic                  req_ready;

   // Held low during reset so no job is accepted on the reset edge.
   assign req_ready = (state_q == StIdle) && !rst;

   always_comb begin
      state_d        = state_q;
      core_en_d      = 1'b0;
      resp_valid_d   = resp_valid_q;
      resp_timeout_d = resp_timeout_q;
      resp_data_d    = resp_data_q;
      core_work_in_d = core_work_in_q;
      core_e_d       = core_e_q;
      cnt_d          = cnt_q;
      err_stray_d    = err_stray_q;

      // A result strobe is only expected in BUSY; anything else is a stray from the core.
      if (bus.core_out_valid && (state_q != StBusy)) begin
         err_stray_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid && req_ready) begin
               core_work_in_d = bus.req_work_in;
               core_e_d       = bus.req_e;
               core_en_d      = 1'b1;
               state_d        = StStart;
            end
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StBusy;
         end
         StBusy: begin
            cnt_d = cnt_q + CNT_BITS'(1);
            // Core result wins over a coincident watchdog expiry.
            if (bus.core_out_valid) begin
               resp_data_d    = bus.core_work_out;
               resp_timeout_d = 1'b0;
               resp_valid_d   = 1'b1;
               state_d        = StDone;
            end else if (cnt_q == CNT_BITS'(TIMEOUT - 1)) begin
               resp_data_d    = '0;
               resp_timeout_d = 1'b1;
               resp_valid_d   = 1'b1;
               state_d        = StDone;
            end
         end
         StDone: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         core_en_q      <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_timeout_q <= 1'b0;
         err_stray_q    <= 1'b0;
         resp_data_q    <= '0;
         core_work_in_q <= '0;
         core_e_q       <= '0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         core_en_q      <= core_en_d;
         resp_valid_q   <= resp_valid_d;
         resp_timeout_q <= resp_timeout_d;
         err_stray_q    <= err_stray_d;
         resp_data_q    <= resp_data_d;
         core_work_in_q <= core_work_in_d;
         core_e_q       <= core_e_d;
         cnt_q          <= cnt_d;
      end
   end

   assign bus.req_ready    = req_ready;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_data    = resp_data_q;
   assign bus.resp_timeout = resp_timeout_q;
   assign bus.core_en      = core_en_q;
   assign bus.core_work_in = core_work_in_q;
   assign bus.core_e       = core_e_q;
   assign busy             = (state_q != StIdle);
   assign err_stray        = err_stray_q;

endmodule

// File: tb/tb_x25519_job_controller.sv
// Bench for x25519_job_controller: a long-timeout instance for the data path and a
// TIMEOUT=16 instance for the watchdog. Each core is modelled behaviourally: it answers
// work_in ^ e a programmable number of cycles after its en pulse.
module tb_x25519_job_controller;
   localparam int unsigned TO_MAIN  = 64;
   localparam int unsigned TO_SHORT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   chk_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   x25519_job_controller_if jif ();
   x25519_job_controller_if tif ();
   logic busy_m, err_m, busy_t, err_t;

   x25519_job_controller #(.TIMEOUT(TO_MAIN)) dut (
      .clk(clk), .rst(rst), .bus(jif), .busy(busy_m), .err_stray(err_m)
   );
   x25519_job_controller #(.TIMEOUT(TO_SHORT)) dut_t (
      .clk(clk), .rst(rst), .bus(tif), .busy(busy_t), .err_stray(err_t)
   );

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Core model for the main instance.
   int           lat_m = 40;
   bit           silent_m = 1'b0;
   bit           stray_m = 1'b0;
   int           pend_m = -1;
   int           en_cnt_m = 0;
   logic [255:0] res_m;
   int           lat_q[$];

   always @(negedge clk) begin
      jif.core_out_valid = 1'b0;
      if (pend_m > 0) begin
         pend_m--;
         if (pend_m == 0) begin
            jif.core_out_valid = 1'b1;
            jif.core_work_out  = res_m;
            pend_m = -1;
         end
      end
      if (stray_m) begin
         jif.core_out_valid = 1'b1;
         jif.core_work_out  = rand256();
         stray_m = 1'b0;
      end
      if (jif.core_en === 1'b1) begin
         en_cnt_m++;
         if (!silent_m) begin
            pend_m = (lat_q.size() > 0) ? lat_q.pop_front() : lat_m;
            res_m  = jif.core_work_in ^ jif.core_e;
         end
      end
   end

   // Core model for the short-timeout instance.
   int           lat_t = 16;
   bit           silent_t = 1'b0;
   int           pend_t = -1;
   logic [255:0] res_t;

   always @(negedge clk) begin
      tif.core_out_valid = 1'b0;
      if (pend_t > 0) begin
         pend_t--;
         if (pend_t == 0) begin
            tif.core_out_valid = 1'b1;
            tif.core_work_out  = res_t;
            pend_t = -1;
         end
      end
      if (tif.core_en === 1'b1 && !silent_t) begin
         pend_t = lat_t;
         res_t  = tif.core_work_in ^ tif.core_e;
      end
   end

   // Offers a job on the main port; acc is the sample index of the accepting cycle.
   task automatic submit_m(input logic [255:0] w, input logic [255:0] e, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      jif.req_valid = 1'b1;
      jif.req_work_in = w;
      jif.req_e = e;
      while (jif.req_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      acc = (n < 1000) ? cyc : -1;
      @(posedge clk);
      #1 jif.req_valid = 1'b0;
   endtask

   // Call at a negedge; returns at the first sample with resp_valid high.
   task automatic wait_resp_m(output int t);
      int n;
      n = 0;
      while (jif.resp_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      t = (n < 2000) ? cyc : -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (jif.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", jif.req_ready);
      else pass_cnt++;
      chk_cnt++;
      if ({jif.resp_valid, jif.core_en, jif.resp_timeout, busy_m, err_m} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {jif.resp_valid, jif.core_en, jif.resp_timeout, busy_m, err_m});
      else pass_cnt++;
      chk_cnt++;
      if ({jif.resp_data, jif.core_work_in, jif.core_e} !== '0)
         $display("FAIL reset_data: got %h %h %h want 0", jif.resp_data, jif.core_work_in,
                  jif.core_e);
      else pass_cnt++;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (jif.req_ready !== 1'b1 || busy_m !== 1'b0)
         $display("FAIL post_reset_idle: req_ready=%b busy=%b want 1 0", jif.req_ready, busy_m);
      else pass_cnt++;
   endtask

   task automatic test_nominal();
      logic [255:0] w, e;
      int acc, t, en0, lat;
      for (int j = 0; j < 3; j++) begin
         if (j == 0) begin
            w = 256'h9; e = 256'h5; lat = 40;
         end else begin
            w = rand256(); e = rand256();
            lat = (j == 1) ? 1 : int'($urandom_range(2, TO_MAIN - 1));
         end
         lat_m = lat;
         en0 = en_cnt_m;
         submit_m(w, e, acc);
         @(negedge clk);
         chk_cnt++;
         if (jif.core_en !== 1'b1) $display("FAIL nom_en_k1[%0d]: got %b want 1", j, jif.core_en);
         else pass_cnt++;
         wait_resp_m(t);
         chk_cnt++;
         if (t != acc + lat + 2)
            $display("FAIL nom_latency[%0d]: got %0d want %0d", j, t - acc, lat + 2);
         else pass_cnt++;
         chk_cnt++;
         if (jif.resp_data !== (w ^ e))
            $display("FAIL nom_data[%0d]: got %h want %h", j, jif.resp_data, w ^ e);
         else pass_cnt++;
         chk_cnt++;
         if (jif.resp_timeout !== 1'b0)
            $display("FAIL nom_timeout[%0d]: got %b want 0", j, jif.resp_timeout);
         else pass_cnt++;
         jif.resp_ready = 1'b1;
         @(posedge clk);
         #1 jif.resp_ready = 1'b0;
         @(negedge clk);
         chk_cnt++;
         if ({jif.resp_valid, busy_m} !== 2'b00)
            $display("FAIL nom_after_ack[%0d]: resp_valid=%b busy=%b want 0 0", j,
                     jif.resp_valid, busy_m);
         else pass_cnt++;
         chk_cnt++;
         if (en_cnt_m - en0 != 1)
            $display("FAIL nom_en_count[%0d]: got %0d want 1", j, en_cnt_m - en0);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] w1, e1, w2, e2;
      int acc, t, bad;
      w1 = rand256(); e1 = rand256(); w2 = rand256(); e2 = rand256();
      lat_m = int'($urandom_range(1, 20));
      submit_m(w1, e1, acc);
      @(negedge clk);
      wait_resp_m(t);
      jif.req_valid = 1'b1;
      jif.req_work_in = w2;
      jif.req_e = e2;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (jif.resp_valid !== 1'b1 || jif.resp_data !== (w1 ^ e1) || jif.resp_timeout !== 1'b0
             || jif.req_ready !== 1'b0 || jif.core_work_in !== w1 || jif.core_e !== e1) bad++;
         @(negedge clk);
      end
      chk_cnt++;
      if (bad != 0) $display("FAIL bp_stable: got %0d bad cycles want 0", bad);
      else pass_cnt++;
      jif.resp_ready = 1'b1;
      @(posedge clk);
      #1 jif.resp_ready = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (jif.req_ready !== 1'b1 || jif.resp_valid !== 1'b0)
         $display("FAIL bp_idle: req_ready=%b resp_valid=%b want 1 0", jif.req_ready,
                  jif.resp_valid);
      else pass_cnt++;
      @(posedge clk);
      #1 jif.req_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (jif.core_en !== 1'b1 || jif.core_work_in !== w2 || jif.core_e !== e2)
         $display("FAIL bp_next_accept: core_en=%b ops=%h/%h want 1 %h/%h", jif.core_en,
                  jif.core_work_in, jif.core_e, w2, e2);
      else pass_cnt++;
      wait_resp_m(t);
      chk_cnt++;
      if (jif.resp_data !== (w2 ^ e2))
         $display("FAIL bp_data2: got %h want %h", jif.resp_data, w2 ^ e2);
      else pass_cnt++;
      jif.resp_ready = 1'b1;
      @(posedge clk);
      #1 jif.resp_ready = 1'b0;
   endtask

   task automatic test_timeout();
      logic [255:0] w, e, exp_d;
      int acc, n;
      for (int j = 0; j < 3; j++) begin
         w = rand256(); e = rand256();
         silent_t = (j == 0);
         lat_t = (j == 1) ? 16 : 17;
         @(negedge clk);
         tif.req_valid = 1'b1;
         tif.req_work_in = w;
         tif.req_e = e;
         n = 0;
         while (tif.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         acc = cyc;
         @(posedge clk);
         #1 tif.req_valid = 1'b0;
         // Sample acc+1 is START; acc+17 is the 16th BUSY cycle.
         repeat (17) @(negedge clk);
         chk_cnt++;
         if (tif.resp_valid !== 1'b0 || cyc != acc + 17)
            $display("FAIL to_early[%0d]: resp_valid=%b at +%0d want 0 at +17", j,
                     tif.resp_valid, cyc - acc);
         else pass_cnt++;
         @(negedge clk);
         exp_d = (j == 1) ? (w ^ e) : 256'h0;
         chk_cnt++;
         if (tif.resp_valid !== 1'b1 || tif.resp_data !== exp_d)
            $display("FAIL to_resp[%0d]: valid=%b data=%h want 1 %h", j, tif.resp_valid,
                     tif.resp_data, exp_d);
         else pass_cnt++;
         chk_cnt++;
         if (tif.resp_timeout !== (j != 1))
            $display("FAIL to_flag[%0d]: got %b want %b", j, tif.resp_timeout, j != 1);
         else pass_cnt++;
         tif.resp_ready = 1'b1;
         @(posedge clk);
         #1 tif.resp_ready = 1'b0;
         @(negedge clk);
         chk_cnt++;
         if (err_t !== (j == 2))
            $display("FAIL to_err_stray[%0d]: got %b want %b", j, err_t, j == 2);
         else pass_cnt++;
      end
   endtask

   task automatic test_stray();
      chk_cnt++;
      if (err_m !== 1'b0) $display("FAIL stray_pre: got %b want 0", err_m);
      else pass_cnt++;
      @(posedge clk);
      #1 stray_m = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (err_m !== 1'b1 || jif.resp_valid !== 1'b0 || busy_m !== 1'b0)
         $display("FAIL stray_set: err=%b resp_valid=%b busy=%b want 1 0 0", err_m,
                  jif.resp_valid, busy_m);
      else pass_cnt++;
      repeat (10) @(negedge clk);
      chk_cnt++;
      if (err_m !== 1'b1) $display("FAIL stray_sticky: got %b want 1", err_m);
      else pass_cnt++;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (err_m !== 1'b0) $display("FAIL stray_clear: got %b want 0", err_m);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [255:0] w, e;
      int acc, seen;
      w = rand256(); e = rand256();
      lat_m = 40;
      submit_m(w, e, acc);
      repeat (11) @(negedge clk);
      chk_cnt++;
      if (busy_m !== 1'b1 || jif.resp_valid !== 1'b0)
         $display("FAIL mid_busy: busy=%b resp_valid=%b want 1 0", busy_m, jif.resp_valid);
      else pass_cnt++;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({jif.req_ready, jif.resp_valid, busy_m, jif.core_en} !== 4'b1000)
         $display("FAIL mid_idle: rdy/rv/busy/en=%b want 1000",
                  {jif.req_ready, jif.resp_valid, busy_m, jif.core_en});
      else pass_cnt++;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (jif.resp_valid !== 1'b0) seen++;
      end
      chk_cnt++;
      if (seen != 0 || err_m !== 1'b1)
         $display("FAIL mid_late_result: resp cycles=%0d err=%b want 0 1", seen, err_m);
      else pass_cnt++;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [255:0] qw[$], qe[$];
      int en0;
      en0 = en_cnt_m;
      for (int i = 0; i < 4; i++) lat_q.push_back(int'($urandom_range(1, 30)));
      jif.resp_ready = 1'b1;
      fork
         begin
            logic [255:0] w, e;
            int acc;
            for (int i = 0; i < 4; i++) begin
               w = rand256(); e = rand256();
               qw.push_back(w);
               qe.push_back(e);
               submit_m(w, e, acc);
            end
         end
         begin
            int got, n, bad;
            got = 0; n = 0; bad = 0;
            while (got < 4 && n < 3000) begin
               @(negedge clk);
               n++;
               if (busy_m === 1'b1 && qw.size() > 0) begin
                  if (jif.core_work_in !== qw[0] || jif.core_e !== qe[0]) bad++;
               end
               if (jif.resp_valid === 1'b1 && qw.size() > 0) begin
                  chk_cnt++;
                  if (jif.resp_data !== (qw[0] ^ qe[0]) || jif.resp_timeout !== 1'b0)
                     $display("FAIL b2b_resp[%0d]: got %h/%b want %h/0", got, jif.resp_data,
                              jif.resp_timeout, qw[0] ^ qe[0]);
                  else pass_cnt++;
                  void'(qw.pop_front());
                  void'(qe.pop_front());
                  got++;
               end
            end
            chk_cnt++;
            if (got != 4) $display("FAIL b2b_count: got %0d responses want 4", got);
            else pass_cnt++;
            chk_cnt++;
            if (bad != 0) $display("FAIL b2b_operands: got %0d bad cycles want 0", bad);
            else pass_cnt++;
         end
      join
      repeat (3) @(negedge clk);
      jif.resp_ready = 1'b0;
      chk_cnt++;
      if (en_cnt_m - en0 != 4) $display("FAIL b2b_en_pulses: got %0d want 4", en_cnt_m - en0);
      else pass_cnt++;
   endtask

   initial begin
      jif.req_valid = 1'b0;
      jif.req_work_in = '0;
      jif.req_e = '0;
      jif.resp_ready = 1'b0;
      tif.req_valid = 1'b0;
      tif.req_work_in = '0;
      tif.req_e = '0;
      tif.resp_ready = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_timeout();
      test_stray();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
